// File: rtl/cdb_broadcaster_pkg.sv
// Shared CDB types and machine-wide constants consumed by the broadcaster, RS, ROB and map table.
package cdb_broadcaster_pkg;
    localparam int ROB_SIZE   = 32;
    localparam int XLEN       = 32;
    localparam int ROB_TAG_W  = $clog2(ROB_SIZE);
    localparam logic [4:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic                 valid;
        logic [ROB_TAG_W-1:0] Tag;
        logic [XLEN-1:0]      Value;
        logic [4:0]           dest_reg_idx;
        logic                 take_branch;
    } CDB_PACKET;

    typedef struct packed {
        logic                 valid;
        logic [ROB_TAG_W-1:0] Tag;
        logic [XLEN-1:0]      Value;
        logic [4:0]           dest_reg_idx;
        logic                 take_branch;
    } EX_CDB_PACKET;
endpackage

// File: rtl/cdb_fifo.sv
// Per-FU completion FIFO: circular buffer with registered occupancy; flush empties it in one edge.
module cdb_fifo
    import cdb_broadcaster_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  EX_CDB_PACKET wdata,
    output EX_CDB_PACKET rdata,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(FIFO_DEPTH);

    EX_CDB_PACKET    mem [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [PW:0]     count;

    assign full  = (count == (PW+1)'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone defines which entries are live.
    always_ff @(posedge clock) begin
        if (!reset && !flush && push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/cdb_broadcaster.sv
// CDB producer: buffers FU completions per unit, round-robin arbitrates, drives a registered CDB packet.
module cdb_broadcaster
    import cdb_broadcaster_pkg::*;
#(
    parameter int NUM_FU     = 4,
    parameter int FIFO_DEPTH = 2,
    parameter int TAG_W      = cdb_broadcaster_pkg::ROB_TAG_W
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   take_branch,
    input  logic [NUM_FU-1:0]      fu_valid,
    output logic [NUM_FU-1:0]      fu_ready,
    input  logic [NUM_FU*TAG_W-1:0] fu_tag,
    input  logic [NUM_FU*XLEN-1:0] fu_value,
    input  logic [NUM_FU*5-1:0]    fu_dest_reg_idx,
    input  logic [NUM_FU-1:0]      fu_take_branch,
    output CDB_PACKET              cdb_packet
);
    localparam int RW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0] push;
    logic [NUM_FU-1:0] pop;
    logic [NUM_FU-1:0] full;
    logic [NUM_FU-1:0] empty;
    logic [NUM_FU-1:0] req;
    EX_CDB_PACKET      head [NUM_FU];

    logic [RW-1:0]     rr_ptr;
    logic [RW-1:0]     grant_idx;
    logic [RW-1:0]     rr_next;
    logic              grant_vld;

    assign fu_ready = ~full;
    assign push     = fu_valid & fu_ready;
    assign req      = ~empty;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
        EX_CDB_PACKET wd;
        assign wd.valid        = 1'b1;
        assign wd.Tag          = fu_tag[i*TAG_W +: TAG_W];
        assign wd.Value        = fu_value[i*XLEN +: XLEN];
        assign wd.dest_reg_idx = fu_dest_reg_idx[i*5 +: 5];
        assign wd.take_branch  = fu_take_branch[i];
        assign pop[i]          = grant_vld && (grant_idx == RW'(i));

        cdb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
            .clock (clock),
            .reset (reset),
            .flush (take_branch),
            .push  (push[i]),
            .pop   (pop[i]),
            .wdata (wd),
            .rdata (head[i]),
            .full  (full[i]),
            .empty (empty[i])
        );
    end

    // Rotate requests so rr_ptr lands at bit 0, take the lowest set bit, rotate the index back.
    always_comb begin
        logic [2*NUM_FU-1:0] dbl;
        logic [NUM_FU-1:0]   rot;
        int                  off;
        int                  sum;
        dbl       = {req, req};
        rot       = NUM_FU'(dbl >> rr_ptr);
        grant_vld = 1'b0;
        off       = 0;
        for (int k = NUM_FU-1; k >= 0; k--) begin
            if (rot[k]) begin
                grant_vld = 1'b1;
                off       = k;
            end
        end
        sum = int'(rr_ptr) + off;
        if (sum >= NUM_FU) sum = sum - NUM_FU;
        grant_idx = RW'(sum);
        rr_next   = (grant_idx == RW'(NUM_FU-1)) ? '0 : grant_idx + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cdb_packet <= '0;
            rr_ptr     <= '0;
        end else if (take_branch) begin
            cdb_packet.valid <= 1'b0;
            rr_ptr           <= '0;
        end else if (grant_vld) begin
            cdb_packet <= CDB_PACKET'(head[grant_idx]);
            rr_ptr     <= rr_next;
        end else begin
            cdb_packet.valid <= 1'b0;
        end
    end
endmodule
